// File: rtl/trena_agendador_pkg.sv
// Shared types for the trena measurement scheduler: FSM state codes and the
// debug code shown when the state register holds an unused value.
package trena_agendador_pkg;

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      ESPERA  = 3'd1,
      DISPARA = 3'd2,
      AGUARDA = 3'd3,
      CONCLUI = 3'd4,
      FALHA   = 3'd5
   } estado_e;

   localparam logic [2:0] DB_INVALIDO = 3'b111;

   // Counter width for a modulus, never below one bit.
   function automatic int largura(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/trena_agendador_contador_m.sv
// Modulus-M timer: zera restarts it, conta advances it, fim flags the M-th
// counted cycle. Implemented as a down-counter with a terminal-count compare.
module contador_m
   import trena_agendador_pkg::*;
#(
   parameter int M = 10
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic zera_i,
   input  logic conta_i,
   output logic fim_o
);

   localparam int W = largura(M);
   localparam logic [W-1:0] TOPO = W'(M - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (zera_i) begin
         cnt_d = TOPO;
      end else if (conta_i) begin
         cnt_d = (cnt_q == '0) ? TOPO : cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= TOPO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fim_o = (cnt_q == '0);

endmodule

// File: rtl/trena_agendador.sv
// Measurement scheduler above the trena: triggers on request or periodically,
// waits for completion with timeout and retries, then flags success or error.
//
//  state   | meaning
//  INICIAL | idle, timers held cleared
//  ESPERA  | continuous mode, counting the period to the next trigger
//  DISPARA | one-cycle trigger pulse to the trena, attempt counted
//  AGUARDA | waiting for trena_pronto, timeout running
//  CONCLUI | success: medida_ok pulse, count++, error cleared
//  FALHA   | attempts exhausted: error set
module trena_agendador
   import trena_agendador_pkg::*;
#(
   parameter int PERIODO_CICLOS = 50_000_000,
   parameter int TIMEOUT_CICLOS = 5_000_000,
   parameter int MAX_TENTATIVAS = 3
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       mensurar_i,
   input  logic       continuo_i,
   input  logic       trena_pronto_i,
   output logic       trena_mensurar_o,
   output logic       medida_ok_o,
   output logic       erro_o,
   output logic       ocupado_o,
   output logic [7:0] num_medidas_o,
   output logic [2:0] db_estado_o
);

   localparam int TW = $clog2(MAX_TENTATIVAS + 1);
   localparam logic [TW-1:0] MAX_T = TW'(MAX_TENTATIVAS);

   estado_e       estado_q, estado_d;
   logic [TW-1:0] tentativas_q, tentativas_d;
   logic [7:0]    num_q, num_d;
   logic          erro_q, erro_d;
   logic          periodo_fim, timeout_fim;

   // Both timers free-run only in their own state and sit cleared elsewhere,
   // so every entry into ESPERA/AGUARDA starts a full interval.
   contador_m #(.M(PERIODO_CICLOS)) u_periodo (
      .clk_i   (clock_i),
      .rst_ni  (reset_ni),
      .zera_i  (estado_q != ESPERA),
      .conta_i (estado_q == ESPERA),
      .fim_o   (periodo_fim)
   );

   contador_m #(.M(TIMEOUT_CICLOS)) u_timeout (
      .clk_i   (clock_i),
      .rst_ni  (reset_ni),
      .zera_i  (estado_q != AGUARDA),
      .conta_i (estado_q == AGUARDA),
      .fim_o   (timeout_fim)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         estado_q     <= INICIAL;
         tentativas_q <= '0;
         num_q        <= '0;
         erro_q       <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         tentativas_q <= tentativas_d;
         num_q        <= num_d;
         erro_q       <= erro_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL: begin
            if (mensurar_i)      estado_d = DISPARA;
            else if (continuo_i) estado_d = ESPERA;
         end
         ESPERA: begin
            if (mensurar_i)       estado_d = DISPARA;
            else if (!continuo_i) estado_d = INICIAL;
            else if (periodo_fim) estado_d = DISPARA;
         end
         DISPARA: estado_d = AGUARDA;
         AGUARDA: begin
            // pronto on the expiry cycle still counts as a success
            if (trena_pronto_i)   estado_d = CONCLUI;
            else if (timeout_fim) estado_d = (tentativas_q < MAX_T) ? DISPARA : FALHA;
         end
         CONCLUI, FALHA: estado_d = continuo_i ? ESPERA : INICIAL;
         default: estado_d = INICIAL;
      endcase
   end

   always_comb begin
      tentativas_d = tentativas_q;
      num_d        = num_q;
      erro_d       = erro_q;
      case (estado_q)
         DISPARA: tentativas_d = tentativas_q + 1'b1;
         CONCLUI: begin
            tentativas_d = '0;
            num_d        = num_q + 8'd1;
            erro_d       = 1'b0;
         end
         FALHA: begin
            tentativas_d = '0;
            erro_d       = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      trena_mensurar_o = 1'b0;
      medida_ok_o      = 1'b0;
      ocupado_o        = 1'b0;
      db_estado_o      = estado_q;
      case (estado_q)
         INICIAL, ESPERA, FALHA: ;
         DISPARA: begin
            trena_mensurar_o = 1'b1;
            ocupado_o        = 1'b1;
         end
         AGUARDA: ocupado_o   = 1'b1;
         CONCLUI: medida_ok_o = 1'b1;
         default: db_estado_o = DB_INVALIDO;
      endcase
   end

   assign erro_o        = erro_q;
   assign num_medidas_o = num_q;

endmodule

// File: tb/tb_trena_agendador.sv
// Bench for trena_agendador: directed scenarios with literal timing checks plus
// randomized traffic, all outputs compared every cycle against a phase model.
module tb_trena_agendador;

   localparam int P = 20;
   localparam int T = 10;
   localparam int M = 3;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       mensurar = 1'b0;
   logic       continuo = 1'b0;
   logic       pronto = 1'b0;
   logic       tm, ok, erro, ocupado;
   logic [7:0] num;
   logic [2:0] db;

   trena_agendador #(
      .PERIODO_CICLOS (P),
      .TIMEOUT_CICLOS (T),
      .MAX_TENTATIVAS (M)
   ) dut (
      .clock_i          (clock),
      .reset_ni         (reset_n),
      .mensurar_i       (mensurar),
      .continuo_i       (continuo),
      .trena_pronto_i   (pronto),
      .trena_mensurar_o (tm),
      .medida_ok_o      (ok),
      .erro_o           (erro),
      .ocupado_o        (ocupado),
      .num_medidas_o    (num),
      .db_estado_o      (db)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Phase model: 0 idle, 1 period wait, 2 fire, 3 await, 4 done, 5 fail.
   typedef struct packed {
      logic [2:0]  ph;
      logic [15:0] el;
      logic [3:0]  tries;
      logic [7:0]  cnt;
      logic        erro;
   } mdl_t;

   mdl_t m_q;

   function automatic mdl_t step(input mdl_t s, input logic mn, input logic ct, input logic pr);
      mdl_t n;
      n = s;
      case (s.ph)
         3'd0: if (mn) n.ph = 3'd2;
               else if (ct) begin n.ph = 3'd1; n.el = 0; end
         3'd1: if (mn) n.ph = 3'd2;
               else if (!ct) n.ph = 3'd0;
               else if (int'(s.el) == P - 1) n.ph = 3'd2;
               else n.el = s.el + 1;
         3'd2: begin n.tries = s.tries + 1; n.el = 0; n.ph = 3'd3; end
         3'd3: if (pr) n.ph = 3'd4;
               else if (int'(s.el) == T - 1) n.ph = (int'(s.tries) < M) ? 3'd2 : 3'd5;
               else n.el = s.el + 1;
         3'd4: begin
            n.cnt = s.cnt + 1; n.erro = 1'b0; n.tries = 0; n.el = 0;
            n.ph = ct ? 3'd1 : 3'd0;
         end
         default: begin
            n.erro = 1'b1; n.tries = 0; n.el = 0;
            n.ph = ct ? 3'd1 : 3'd0;
         end
      endcase
      return n;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) m_q <= '0;
      else          m_q <= step(m_q, mensurar, continuo, pronto);
   end

   int checks = 0;
   int passes = 0;
   int n_trig = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic compare_cycle();
      chk("trena_mensurar", int'(tm), int'(m_q.ph == 3'd2));
      chk("medida_ok", int'(ok), int'(m_q.ph == 3'd4));
      chk("ocupado", int'(ocupado), int'(m_q.ph == 3'd2 || m_q.ph == 3'd3));
      chk("erro", int'(erro), int'(m_q.erro));
      chk("num_medidas", int'(num), int'(m_q.cnt));
      chk("db_estado", int'(db), int'(m_q.ph));
      if (tm) n_trig++;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      compare_cycle();
   endtask

   task automatic shoot(output int at);
      mensurar = 1'b1;
      tick();
      mensurar = 1'b0;
      at = cyc;
      chk("latency_trigger", int'(tm), 1);
   endtask

   task automatic wait_trig(input int budget, output int at);
      bit found;
      found = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !found; i++) begin
         tick();
         if (tm) begin found = 1'b1; at = cyc; end
      end
      if (!found) chk("wait_trigger_timeout", 0, 1);
   endtask

   initial begin
      int t0, t1, t2, base;
      int tc[3];

      #2;
      chk("reset_tm", int'(tm), 0);
      chk("reset_ok", int'(ok), 0);
      chk("reset_ocupado", int'(ocupado), 0);
      chk("reset_erro", int'(erro), 0);
      chk("reset_num", int'(num), 0);
      chk("reset_db", int'(db), 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) tick();

      // single shot, pronto 5 cycles after trigger
      base = n_trig;
      shoot(t0);
      repeat (5) tick();
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      chk("single_ok_at_trig_plus_6", int'(ok), 1);
      chk("single_ok_cycle", cyc - t0, 6);
      tick();
      chk("single_num", int'(num), 1);
      chk("single_db_idle", int'(db), 0);
      chk("single_one_trigger", n_trig - base, 1);

      // timeout and retries
      base = n_trig;
      shoot(t0);
      wait_trig(20, t1);
      wait_trig(20, t2);
      chk("retry_gap1", t1 - t0, 11);
      chk("retry_gap2", t2 - t1, 11);
      for (int i = 0; i < 40 && cyc < t0 + 33; i++) tick();
      chk("retry_falha_state", int'(db), 5);
      tick();
      chk("retry_erro_set", int'(erro), 1);
      chk("retry_db_idle", int'(db), 0);
      chk("retry_three_triggers", n_trig - base, 3);

      // success clears erro
      shoot(t0);
      tick();
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      chk("clear_ok", int'(ok), 1);
      chk("clear_erro_still_set", int'(erro), 1);
      tick();
      chk("clear_erro_cleared", int'(erro), 0);
      chk("clear_num", int'(num), 2);

      // pronto on the timeout-expiry cycle
      shoot(t0);
      repeat (10) tick();
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      chk("race_ok", int'(ok), 1);
      base = n_trig;
      repeat (15) tick();
      chk("race_no_retry", n_trig - base, 0);

      // continuous mode
      continuo = 1'b1;
      wait_trig(30, tc[0]);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) wait_trig(40, tc[i]);
         repeat (3) tick();
         pronto = 1'b1;
         tick();
         pronto = 1'b0;
      end
      chk("cont_gap1", tc[1] - tc[0], 25);
      chk("cont_gap2", tc[2] - tc[1], 25);
      repeat (5) tick();
      continuo = 1'b0;
      tick();
      chk("cont_off_idle", int'(db), 0);
      base = n_trig;
      repeat (40) tick();
      chk("cont_off_no_trig", n_trig - base, 0);

      // async reset while waiting for pronto
      shoot(t0);
      repeat (3) tick();
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_ocupado", int'(ocupado), 0);
      chk("arst_tm", int'(tm), 0);
      chk("arst_db", int'(db), 0);
      chk("arst_num", int'(num), 0);
      @(negedge clock);
      compare_cycle();
      reset_n = 1'b1;
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      chk("arst_late_pronto_ignored", int'(ok), 0);
      tick();
      chk("arst_num_after", int'(num), 0);

      // 256 successful shots wrap the count
      for (int i = 0; i < 256; i++) begin
         shoot(t0);
         tick();
         pronto = 1'b1;
         tick();
         pronto = 1'b0;
         tick();
         if (i == 254) chk("wrap_255", int'(num), 255);
      end
      chk("wrap_0", int'(num), 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         mensurar = ($urandom_range(0, 24) == 0);
         pronto   = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 149) == 0) continuo = ~continuo;
         tick();
      end
      mensurar = 1'b0;
      pronto   = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

endmodule
